// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through or registered-read
// output, programmable almost-full/almost-empty thresholds, an occupancy count
// and sticky overflow/underflow error flags.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds sized to the count width so the flag compares stay exact.
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Storage is intentionally not reset; only the pointers define its contents.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic          underflow_reg;
  logic          wr_accept;
  logic          rd_accept;

  // Status flags decode from the registered count only, so they reflect the
  // state before the current edge: a simultaneous read never frees a slot for
  // a write when full, and a write never feeds a read when empty.
  assign full         = (count_reg == DEPTH_C);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  assign wr_accept = w_en & ~full;
  assign rd_accept = r_en & ~empty;

  // Occupancy moves only when exactly one side of the FIFO is accepted.
  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Memory write port; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) mem[wr_ptr_reg] <= data_in;
  end

  // Sticky error flags; a new error in the same cycle beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (w_en && full)  overflow_reg <= 1'b1;
      else if (clr_err)  overflow_reg <= 1'b0;
      if (r_en && empty) underflow_reg <= 1'b1;
      else if (clr_err)  underflow_reg <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is always presented; r_en acknowledges it.
      assign data_out = mem[rd_ptr_reg];
      assign valid    = ~empty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] data_out_reg;
      logic                  valid_reg;

      // One-cycle read latency: data registers on an accepted read and holds
      // otherwise, while valid pulses for exactly that one cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out_reg <= '0;
          valid_reg    <= 1'b0;
        end else begin
          valid_reg <= rd_accept;
          if (rd_accept) data_out_reg <= mem[rd_ptr_reg];
        end
      end

      assign data_out = data_out_reg;
      assign valid    = valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: one registered-read instance and one
// FWFT instance (both DEPTH=8, AF=6, AE=2) driven from a single sequence.
module tb_sync_fifo_fwft;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_err;

  // Registered-read instance
  logic          w_en, r_en;
  logic [DW-1:0] data_in, data_out;
  logic          valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  // FWFT instance
  logic          b_w_en, b_r_en;
  logic [DW-1:0] b_data_in, b_data_out;
  logic          b_valid, b_full, b_empty, b_almost_full, b_almost_empty;
  logic          b_overflow, b_underflow;
  logic [CW-1:0] b_count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .clr_err(clr_err),
    .data_out(data_out), .valid(valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(b_w_en), .data_in(b_data_in), .r_en(b_r_en), .clr_err(clr_err),
    .data_out(b_data_out), .valid(b_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_almost_full), .almost_empty(b_almost_empty), .count(b_count),
    .overflow(b_overflow), .underflow(b_underflow)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full status snapshot of the registered-read instance.
  task automatic chk_a(input string tag, input int c, input int e, input int f,
                       input int ae, input int af, input int ov, input int un);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  logic [DW-1:0] fill_vec [8];

  initial begin
    fill_vec[0] = 8'd32; fill_vec[1] = 8'd41; fill_vec[2] = 8'd51; fill_vec[3] = 8'd12;
    fill_vec[4] = 8'd73; fill_vec[5] = 8'd43; fill_vec[6] = 8'd84; fill_vec[7] = 8'd1;

    // ---- Reset with both requests asserted ----
    rst = 1'b1; clr_err = 1'b0;
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
    b_w_en = 1'b1; b_r_en = 1'b1; b_data_in = 8'hEE;
    tick(); tick();
    chk_a("reset", 0, 1, 0, 1, 0, 0, 0);
    chk("reset.valid", 32'(valid), 32'd0);
    chk("reset.data_out", 32'(data_out), 32'd0);
    chk("reset.b_valid", 32'(b_valid), 32'd0);
    chk("reset.b_count", 32'(b_count), 32'd0);
    chk("reset.b_empty", 32'(b_empty), 32'd1);
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0;
    tick();
    chk_a("idle", 0, 1, 0, 1, 0, 0, 0);

    // ---- Fill: almost_empty drops after 3rd, almost_full after 6th, full after 8th ----
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; data_in = fill_vec[i];
      tick();
      chk_a($sformatf("fill%0d", i), i + 1, 0, int'(i == 7), int'(i < 2), int'(i >= 5), 0, 0);
    end

    // ---- Overflow: 9th write rejected ----
    data_in = 8'd99;
    tick();
    w_en = 1'b0;
    chk_a("ovf", 8, 0, 1, 0, 1, 1, 0);

    // ---- Drain: same order, valid each cycle after r_en ----
    for (int i = 0; i < 8; i++) begin
      r_en = 1'b1;
      tick();
      chk($sformatf("drain%0d.valid", i), 32'(valid), 32'd1);
      chk($sformatf("drain%0d.data", i), 32'(data_out), 32'(fill_vec[i]));
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(7 - i));
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // ---- Underflow: read on empty; data_out holds the last word ----
    tick();
    r_en = 1'b0;
    chk_a("unf", 0, 1, 0, 1, 0, 1, 1);
    chk("unf.valid", 32'(valid), 32'd0);
    chk("unf.data_hold", 32'(data_out), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk_a("clr", 0, 1, 0, 1, 0, 0, 0);

    // ---- Simultaneous read/write at count=3 ----
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; data_in = 8'(8'd10 + i);
      tick();
    end
    chk("sim.pre_count", 32'(count), 32'd3);
    for (int i = 0; i < 4; i++) begin
      w_en = 1'b1; r_en = 1'b1; data_in = 8'(8'd13 + i);
      tick();
      chk($sformatf("sim%0d.count", i), 32'(count), 32'd3);
      chk($sformatf("sim%0d.valid", i), 32'(valid), 32'd1);
      chk($sformatf("sim%0d.data", i), 32'(data_out), 32'(10 + i));
    end
    w_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("simd%0d.data", i), 32'(data_out), 32'(14 + i));
    end
    r_en = 1'b0;
    tick();
    chk_a("sim.end", 0, 1, 0, 1, 0, 0, 0);

    // ---- Both at full, with clr_err: read only, overflow set beats clear ----
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; data_in = 8'(8'h20 + i);
      tick();
    end
    chk("full2.count", 32'(count), 32'd8);
    w_en = 1'b1; r_en = 1'b1; clr_err = 1'b1; data_in = 8'h55;
    tick();
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    chk_a("bothfull", 7, 0, 0, 0, 1, 1, 0);
    chk("bothfull.data", 32'(data_out), 32'h20);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("bothfull.clr", 32'(overflow), 32'd0);
    r_en = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("bfd%0d.data", i), 32'(data_out), 32'(8'h20 + i));
    end
    r_en = 1'b0;
    tick();
    chk_a("bfd.end", 0, 1, 0, 1, 0, 0, 0);

    // ---- Both at empty: write only, underflow set ----
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h77;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk_a("bothempty", 1, 0, 0, 1, 0, 0, 1);
    chk("bothempty.valid", 32'(valid), 32'd0);
    r_en = 1'b1; clr_err = 1'b1;
    tick();
    r_en = 1'b0; clr_err = 1'b0;
    chk("bothempty.data", 32'(data_out), 32'h77);
    chk_a("bothempty.end", 0, 1, 0, 1, 0, 0, 0);

    // ---- Wrap-around: 20 words 0..19 streamed through ----
    w_en = 1'b1; data_in = 8'd0;
    tick();
    for (int i = 1; i <= 20; i++) begin
      w_en = (i < 20); r_en = 1'b1; data_in = 8'(i);
      tick();
      chk($sformatf("wrap%0d.data", i - 1), 32'(data_out), 32'(i - 1));
      chk($sformatf("wrap%0d.valid", i - 1), 32'(valid), 32'd1);
    end
    w_en = 1'b0; r_en = 1'b0;
    tick();
    chk_a("wrap.end", 0, 1, 0, 1, 0, 0, 0);

    // ---- FWFT: word falls through without r_en, r_en pops it ----
    b_w_en = 1'b1; b_data_in = 8'hA5;
    tick();
    b_w_en = 1'b0;
    chk("fwft.valid", 32'(b_valid), 32'd1);
    chk("fwft.data", 32'(b_data_out), 32'hA5);
    tick();
    chk("fwft.hold_valid", 32'(b_valid), 32'd1);
    chk("fwft.hold_data", 32'(b_data_out), 32'hA5);
    b_r_en = 1'b1;
    tick();
    b_r_en = 1'b0;
    chk("fwft.pop_valid", 32'(b_valid), 32'd0);
    chk("fwft.pop_empty", 32'(b_empty), 32'd1);
    b_w_en = 1'b1; b_data_in = 8'h11;
    tick();
    b_data_in = 8'h22;
    tick();
    b_w_en = 1'b0;
    chk("fwft2.count", 32'(b_count), 32'd2);
    chk("fwft2.head", 32'(b_data_out), 32'h11);
    b_r_en = 1'b1;
    tick();
    chk("fwft2.next_valid", 32'(b_valid), 32'd1);
    chk("fwft2.next_data", 32'(b_data_out), 32'h22);
    tick();
    b_r_en = 1'b0;
    chk("fwft2.end_valid", 32'(b_valid), 32'd0);
    chk("fwft2.underflow", 32'(b_underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock FIFO, successor to the basic synchronous FIFO on the UART-to-DDR data path. Adds selectable first-word-fall-through (FWFT) or registered-read mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It buffers bytes or words between the UART receive side and the AXI write master.

## Interface
- DATA_WIDTH, 8, word width in bits
- DEPTH, 16, number of entries; power of two, >= 4
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; 0..DEPTH-1
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- w_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- r_en  input  1  read request (pop in FWFT mode)
- clr_err  input  1  clears overflow/underflow
- data_out  output  DATA_WIDTH  read data
- valid  output  1  data_out is valid (meaning per mode, below)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH
- count  output  $clog2(DEPTH)+1  stored words, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. wr_ptr/rd_ptr are $clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
- Write accepted iff w_en && !full; stores data_in at wr_ptr, wr_ptr++.
- Read accepted iff r_en && !empty; rd_ptr++.
- full/empty sampled before the edge; a read in the same cycle does NOT make room for a write when full, and a write does NOT satisfy a read when empty.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- full, empty, almost_full, almost_empty decoded combinationally from registered count.
- overflow set on w_en && full; underflow set on r_en && empty. Held until clr_err; set condition wins over clr_err in the same cycle.
- Registered mode (FWFT=0): on an accepted read, data_out <= mem[rd_ptr] and valid <= 1 for exactly one cycle; otherwise data_out holds, valid <= 0.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] whenever !empty; valid = !empty. r_en acknowledges the presented word. data_out undefined-but-stable-at-last-value is not required; bench checks data_out only when valid=1.

## Timing
- Reset (rst=1 at an edge): pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, valid=0, data_out=0 (registered mode). Reset mid-operation discards all stored data; w_en/r_en ignored in the reset cycle.
- Write at edge N: count, flags update after edge N. FWFT: word visible with valid=1 in cycle after edge N when FIFO was empty.
- Registered read: r_en accepted at edge N -> data_out/valid valid in cycle after edge N (1-cycle latency).
- FWFT read: r_en accepted at edge N -> next word (or valid=0) after edge N (0-cycle latency).
- Back-to-back reads/writes every cycle supported; throughput 1 word/cycle each direction.

## Test plan
- Reset: drive rst=1 for 2 cycles with w_en=r_en=1 -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, valid=0.
- Fill/drain (DEPTH=8, AF_THRESH=6, AE_THRESH=2, FWFT=0): write 32,41,51,12,73,43,84,1 -> almost_empty drops after 3rd write, almost_full after 6th, full after 8th; 8 reads return same order, valid pulses each cycle after r_en, empty=1 at end.
- Overflow/underflow: write 9th word 99 while full -> rejected, overflow=1, count=8; drain then r_en on empty -> underflow=1, data_out holds 1; clr_err -> both 0.
- Simultaneous: with count=3, w_en=r_en=1 for 4 cycles -> count stays 3, data order preserved; at count=8 with both -> read only, count=7, overflow=1.
- Wrap-around: 20 write/read pairs through DEPTH=8 with incrementing data 0..19 -> output exactly 0..19, no flags.
- FWFT=1: write 0xA5 into empty FIFO -> valid=1, data_out=0xA5 next cycle without r_en; r_en for one cycle -> valid=0, empty=1.
